sprite_line_scanout: RTL and testbench

- Double-buffered line buffer between the sprite renderer and the video output path.
- The renderer writes the pixels of line N+1 into the back bank through the same r_addr/r_we port it already drives. At the same time, the front bank (line N) is streamed out at pixel rate and cleared behind the read pointer.
- Banks swap on each line_start pulse from video timing.

---
 rtl/sprite_line_scanout_if.sv | 14 +
 rtl/sprite_line_scanout.sv | 193 +++++++++++++++++++
 tb/tb_sprite_line_scanout.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scanout_if.sv
// Renderer-side write bus of the sprite line buffer.
// The renderer (master) drives x position, colour and write strobe;
// the line buffer (slave) answers with r_ready.
interface sprite_line_scanout_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_we;
    logic              r_ready;

    modport master (output r_addr, output r_data, output r_we, input r_ready);
    modport slave  (input r_addr, input r_data, input r_we, output r_ready);
endinterface

// File: rtl/sprite_line_scanout.sv
// Double-buffered sprite line buffer.
// The renderer fills the back bank while the front bank is streamed out at
// pixel rate and wiped to TRANSPARENT right behind the read pointer, so each
// bank comes back empty for the next line it has to collect.
module sprite_line_scanout #(
    parameter int         H_ACTIVE    = 320,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 line_start,
    input  logic                 pix_en,
    sprite_line_scanout_if.slave rnd,
    output logic [7:0]           pix_out,
    output logic                 pix_valid,
    output logic                 front_bank,
    output logic                 short_line
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] X_END  = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] X_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_ACTIVE,
        SCAN_DONE
    } scan_state_t;

    typedef enum logic [1:0] {
        CLR_INIT,
        CLR_IDLE,
        CLR_FLUSH
    } clr_state_t;

    scan_state_t       scan_state;
    clr_state_t        clr_state;
    logic [ADDR_W-1:0] rd_x;
    logic [ADDR_W-1:0] clr_ptr;
    logic              ready_q;

    logic [7:0]        bank0 [DEPTH];
    logic [7:0]        bank1 [DEPTH];

    logic              back_bank;
    logic              swap;
    logic              scan_rd;
    logic              short_now;
    logic              rnd_wr;
    logic [7:0]        front_pixel;

    logic              we    [2];
    logic [ADDR_W-1:0] waddr [2];
    logic [7:0]        wdata [2];

    assign back_bank   = ~front_bank;
    // Line starts are meaningless until both banks have been wiped once.
    assign swap        = line_start && (clr_state != CLR_INIT);
    assign scan_rd     = pix_en && (scan_state == SCAN_ACTIVE);
    assign short_now   = swap && (scan_state == SCAN_ACTIVE) && (rd_x < X_END);
    assign rnd_wr      = rnd.r_we && ready_q && (rnd.r_addr < X_END) &&
                         (rnd.r_data != TRANSPARENT);
    assign front_pixel = front_bank ? bank1[rd_x] : bank0[rd_x];
    assign rnd.r_ready = ready_q;

    // One write port per bank: init wipes both, flush and renderer share the
    // back bank (never together, r_ready is low during flush), and the scan
    // wipes the front bank behind its read pointer.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b]    = 1'b0;
            waddr[b] = '0;
            wdata[b] = TRANSPARENT;
        end
        if (clr_state == CLR_INIT) begin
            for (int b = 0; b < 2; b++) begin
                we[b]    = 1'b1;
                waddr[b] = clr_ptr;
            end
        end else begin
            if (clr_state == CLR_FLUSH) begin
                we[back_bank]    = 1'b1;
                waddr[back_bank] = clr_ptr;
            end else if (rnd_wr) begin
                we[back_bank]    = 1'b1;
                waddr[back_bank] = rnd.r_addr;
                wdata[back_bank] = rnd.r_data;
            end
            if (scan_rd) begin
                we[front_bank]    = 1'b1;
                waddr[front_bank] = rd_x;
            end
        end
    end

    // Bank storage; contents are not reset, the init pass wipes them instead.
    always_ff @(posedge clk) begin
        if (we[0]) bank0[waddr[0]] <= wdata[0];
        if (we[1]) bank1[waddr[1]] <= wdata[1];
    end

    // Clear machine: power-up wipe of both banks, then flushes the unread tail
    // of a bank that was swapped out before its line finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state  <= CLR_INIT;
            clr_ptr    <= '0;
            ready_q    <= 1'b0;
            short_line <= 1'b0;
        end else begin
            if (short_now) short_line <= 1'b1;
            case (clr_state)
                CLR_INIT: begin
                    if (clr_ptr == X_LAST) begin
                        clr_state <= CLR_IDLE;
                        clr_ptr   <= '0;
                        ready_q   <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + X_ONE;
                    end
                end
                CLR_IDLE: begin
                    if (short_now) begin
                        clr_state <= CLR_FLUSH;
                        clr_ptr   <= rd_x;
                        ready_q   <= 1'b0;
                    end
                end
                CLR_FLUSH: begin
                    if (short_now) begin
                        clr_ptr <= rd_x;
                    end else if (swap || (clr_ptr == X_LAST)) begin
                        clr_state <= CLR_IDLE;
                        clr_ptr   <= '0;
                        ready_q   <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + X_ONE;
                    end
                end
                default: begin
                    clr_state <= CLR_INIT;
                    clr_ptr   <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Scan machine: bank swap on line_start and pixel-rate readout with a
    // one-cycle registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_state <= SCAN_IDLE;
            rd_x       <= '0;
            front_bank <= 1'b0;
            pix_out    <= TRANSPARENT;
            pix_valid  <= 1'b0;
        end else begin
            pix_valid <= pix_en;
            if (scan_rd) begin
                pix_out <= front_pixel;
            end else if (pix_en) begin
                pix_out <= TRANSPARENT;
            end
            if (swap) begin
                front_bank <= ~front_bank;
            end
            case (scan_state)
                SCAN_IDLE, SCAN_DONE: begin
                    if (swap) begin
                        scan_state <= SCAN_ACTIVE;
                        rd_x       <= '0;
                    end
                end
                SCAN_ACTIVE: begin
                    if (swap) begin
                        rd_x <= '0;
                    end else if (pix_en) begin
                        rd_x <= rd_x + X_ONE;
                        if (rd_x == X_LAST) scan_state <= SCAN_DONE;
                    end
                end
                default: begin
                    scan_state <= SCAN_IDLE;
                    rd_x       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_scanout.sv
// Bench for sprite_line_scanout: directed scenarios with hand-computed
// expectations, then randomized lines, all checked every cycle against a
// line-buffer model built from plain arrays and counters.
module tb_sprite_line_scanout;

    localparam int H  = 320;
    localparam int AW = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line_start;
    logic       pix_en;
    logic [7:0] pix_out;
    logic       pix_valid;
    logic       front_bank;
    logic       short_line;

    int check_count = 0;
    int pass_count  = 0;
    bit cmp_en      = 1'b0;
    bit cap_en      = 1'b0;
    logic [7:0] cap_q [$];

    sprite_line_scanout_if #(.ADDR_W(AW)) rnd_if ();

    sprite_line_scanout #(
        .H_ACTIVE   (H),
        .ADDR_W     (AW),
        .TRANSPARENT(8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_start(line_start),
        .pix_en    (pix_en),
        .rnd       (rnd_if.slave),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .front_bank(front_bank),
        .short_line(short_line)
    );

    always #5 clk = ~clk;

    // Model state: two line arrays, the displayed bank, how many pixels of the
    // current line were consumed, and how long the renderer is locked out.
    logic [7:0] model_buf [2][H];
    bit         m_front, m_ready, m_short, m_init, m_scanning, m_valid;
    logic [7:0] m_pix;
    int         m_rdcnt, m_busy;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic modelStep();
        bit f, in_init, active, short_now;
        int rc0, a;
        f         = m_front;
        in_init   = m_init;
        rc0       = m_rdcnt;
        active    = m_scanning && (m_rdcnt < H);
        short_now = line_start && !in_init && active;
        a         = int'(rnd_if.r_addr);
        m_valid   = pix_en;
        if (pix_en) begin
            if (active) begin
                m_pix = model_buf[f][m_rdcnt];
                model_buf[f][m_rdcnt] = 8'h00;
                m_rdcnt++;
            end else begin
                m_pix = 8'h00;
            end
        end
        if (rnd_if.r_we && m_ready && a < H && rnd_if.r_data != 8'h00)
            model_buf[!f][a] = rnd_if.r_data;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_ready = 1'b1;
                m_init  = 1'b0;
            end
        end
        if (line_start && !in_init) begin
            m_front    = !f;
            m_scanning = 1'b1;
            m_rdcnt    = 0;
            if (short_now) begin
                m_short = 1'b1;
                for (int i = rc0; i < H; i++) model_buf[f][i] = 8'h00;
                m_busy  = H - rc0;
                m_ready = 1'b0;
            end else if (m_busy > 0) begin
                m_busy  = 0;
                m_ready = 1'b1;
            end
        end
    endtask

    // Advance the model on every clock edge; reset wipes it like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < H; i++) model_buf[b][i] = 8'h00;
            m_front = 0; m_ready = 0; m_short = 0; m_init = 1;
            m_scanning = 0; m_valid = 0; m_pix = 8'h00; m_rdcnt = 0; m_busy = H;
        end else begin
            modelStep();
        end
    end

    // Compare every registered output against the model away from the edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("pix_valid", int'(pix_valid), int'(m_valid));
            checkOutput("pix_out", int'(pix_out), int'(m_pix));
            checkOutput("front_bank", int'(front_bank), int'(m_front));
            checkOutput("r_ready", int'(rnd_if.r_ready), int'(m_ready));
            checkOutput("short_line", int'(short_line), int'(m_short));
        end
    end

    task automatic applyStimulus(input bit ls, input bit pe, input bit we,
                                 input int addr, input logic [7:0] data);
        @(negedge clk);
        if (cap_en && pix_valid) cap_q.push_back(pix_out);
        line_start    = ls;
        pix_en        = pe;
        rnd_if.r_we   = we;
        rnd_if.r_addr = AW'(addr);
        rnd_if.r_data = data;
    endtask

    task automatic readLine(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic waitReady(input int bound);
        int n;
        n = 0;
        while (rnd_if.r_ready !== 1'b1 && n < bound) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
            n++;
        end
        if (n >= bound) checkOutput("ready_timeout", int'(rnd_if.r_ready), 1);
    endtask

    function automatic int capAt(input int i);
        return (i < cap_q.size()) ? int'(cap_q[i]) : -1;
    endfunction

    function automatic int capNonZero();
        int n;
        n = 0;
        foreach (cap_q[i]) if (cap_q[i] != 8'h00) n++;
        return n;
    endfunction

    // Hard stop in case the design wedges the stimulus.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_seq [8];
        int low_cnt, pe_cnt, len, n;
        bit pe, we;
        exp_seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h00, 8'h00};

        rst_n = 1'b0; line_start = 1'b0; pix_en = 1'b0;
        rnd_if.r_we = 1'b0; rnd_if.r_addr = '0; rnd_if.r_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        $display("[TB] reset released, init pass running");

        // Init: r_ready after exactly 320 edges, line_start at 100 ignored.
        for (int c = 1; c <= H; c++) begin
            applyStimulus(c == 100, 1'b0, 1'b0, 0, 8'h00);
            if (c == H - 1) checkOutput("ready_at_319", int'(rnd_if.r_ready), 0);
        end
        checkOutput("ready_at_320", int'(rnd_if.r_ready), 1);
        checkOutput("front_after_init", int'(front_bank), 0);

        // Opaque pixel at x=5, transparent write at x=6 dropped.
        applyStimulus(1'b0, 1'b0, 1'b1, 5, 8'h2A);
        applyStimulus(1'b0, 1'b0, 1'b1, 6, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        cap_q.delete(); cap_en = 1'b1;
        readLine(8);
        cap_en = 1'b0;
        checkOutput("seq_len", cap_q.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("seq_pixel", capAt(i), int'(exp_seq[i]));
        checkOutput("front_after_swap", int'(front_bank), 1);
        readLine(H - 8);

        // Full lines: clipped write, then the bank read earlier comes back empty.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 400, 8'h11);
        readLine(H - 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        cap_q.delete(); cap_en = 1'b1;
        readLine(H);
        cap_en = 1'b0;
        checkOutput("reread_len", cap_q.size(), H);
        checkOutput("reread_nonzero", capNonZero(), 0);

        // Short line: flush of the tail, renderer locked out for 220 cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 150, 8'h55);
        applyStimulus(1'b0, 1'b0, 1'b1, 50, 8'h66);
        applyStimulus(1'b0, 1'b0, 1'b1, 319, 8'h77);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        cap_q.delete(); cap_en = 1'b1;
        readLine(100);
        cap_en = 1'b0;
        checkOutput("short_px50", capAt(50), 8'h66);
        checkOutput("short_px49", capAt(49), 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        low_cnt = 0; pe_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b0, 1'b1, k == 5, 200, 8'h99);
            pe_cnt++;
            if (rnd_if.r_ready === 1'b1) break;
            low_cnt++;
        end
        checkOutput("flush_low_cycles", low_cnt, 220);
        checkOutput("short_flag", int'(short_line), 1);
        if (pe_cnt < H) readLine(H - pe_cnt);
        else applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        cap_q.delete(); cap_en = 1'b1;
        readLine(H);
        cap_en = 1'b0;
        checkOutput("flushed_len", cap_q.size(), H);
        checkOutput("flushed_nonzero", capNonZero(), 0);

        // Write coincident with line_start lands in the line now displayed.
        applyStimulus(1'b1, 1'b0, 1'b1, 3, 8'h7F);
        cap_q.delete(); cap_en = 1'b1;
        readLine(8);
        cap_en = 1'b0;
        checkOutput("coincident_px3", capAt(3), 8'h7F);
        checkOutput("coincident_px2", capAt(2), 8'h00);
        readLine(H - 8);

        // Asynchronous reset in the middle of a line.
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 8'h44);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        readLine(50);
        #2 rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        rst_n = 1'b1;
        checkOutput("reset_front", int'(front_bank), 0);
        checkOutput("reset_short", int'(short_line), 0);
        checkOutput("reset_ready", int'(rnd_if.r_ready), 0);
        waitReady(400);

        // Randomized lines: random lengths, gaps, writes (some clipped or transparent).
        for (int line = 0; line < 14; line++) begin
            waitReady(400);
            applyStimulus(1'b1, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 399),
                          8'($urandom_range(0, 255)));
            len = ($urandom_range(0, 2) != 0) ? H : $urandom_range(1, H - 1);
            n = 0;
            while (n < len) begin
                pe = ($urandom_range(0, 3) != 0);
                we = ($urandom_range(0, 4) < 2);
                applyStimulus(1'b0, pe, we, $urandom_range(0, 399),
                              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
                if (pe) n++;
            end
            repeat ($urandom_range(1, 5))
                applyStimulus(1'b0, 1'b0, 1'b1, $urandom_range(0, 399),
                              8'($urandom_range(0, 255)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);

        cmp_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
